// File: rtl/epp_panel_rx.sv
// epp_panel_rx: panel-side loopback receiver for the EPP source/gate bus.
// Oversamples the panel pins with sys_clk, decodes SPV/CKV/SPH/CL/LE
// framing into a tagged byte stream and keeps per-line/per-frame checks.
module epp_panel_rx #(
    parameter int H_BYTES = 240,
    parameter int V_LINES = 540,
    parameter int XW      = 8,
    parameter int YW      = 10
) (
    input  logic          sys_clk,
    input  logic          sys_nrst,
    input  logic          epd_spv,
    input  logic          epd_ckv,
    input  logic          epd_sph,
    input  logic          epd_cl,
    input  logic          epd_le,
    input  logic [7:0]    epd_d,
    output logic          pix_valid,
    output logic [7:0]    pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          line_done,
    output logic          line_err,
    output logic          frame_done,
    output logic          frame_err,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        VSTART,
        WAIT_SPH,
        DATA,
        WAIT_LE
    } state_t;

    localparam logic [8:0]    H_CNT  = 9'(H_BYTES);
    localparam logic [YW-1:0] LAST_Y = YW'(V_LINES - 1);

    state_t state;

    // Bit 0 is the first synchronizer flop, bit 1 the usable synchronized
    // level, bit 2 the delayed copy used for edge detection.
    logic [2:0] spv_sr;
    logic [2:0] ckv_sr;
    logic [2:0] cl_sr;
    logic [2:0] le_sr;
    logic [1:0] sph_sr;
    logic [7:0] d_s1;
    logic [7:0] d_s2;

    logic       spv_s;
    logic       sph_s;
    logic       spv_fall;
    logic       ckv_rise;
    logic       cl_rise;
    logic       le_rise;
    logic       row_last;

    logic [8:0] byte_cnt;

    // Synchronize every panel pin; reset values are the idle bus levels so
    // no spurious edge is seen when reset is released on an idle bus.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            spv_sr <= 3'b111;
            ckv_sr <= 3'b000;
            cl_sr  <= 3'b000;
            le_sr  <= 3'b000;
            sph_sr <= 2'b11;
            d_s1   <= 8'h00;
            d_s2   <= 8'h00;
        end else begin
            spv_sr <= {spv_sr[1:0], epd_spv};
            ckv_sr <= {ckv_sr[1:0], epd_ckv};
            cl_sr  <= {cl_sr[1:0],  epd_cl};
            le_sr  <= {le_sr[1:0],  epd_le};
            sph_sr <= {sph_sr[0],   epd_sph};
            d_s1   <= epd_d;
            d_s2   <= d_s1;
        end
    end

    // Edge detectors and row-limit flag derived from synchronized levels only.
    always_comb begin
        spv_s    = spv_sr[1];
        sph_s    = sph_sr[1];
        spv_fall = ~spv_sr[1] & spv_sr[2];
        ckv_rise = ckv_sr[1] & ~ckv_sr[2];
        cl_rise  = cl_sr[1] & ~cl_sr[2];
        le_rise  = le_sr[1] & ~le_sr[2];
        row_last = (pix_y == LAST_Y);
    end

    // Frame/line decoder with registered strobes, tags and sticky error flags.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state      <= IDLE;
            pix_valid  <= 1'b0;
            pix_data   <= 8'h00;
            pix_x      <= '0;
            pix_y      <= '0;
            line_done  <= 1'b0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 16'h0000;
            byte_cnt   <= 9'd0;
        end else begin
            pix_valid  <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;

            if (le_rise && (state != WAIT_LE)) begin
                line_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    pix_y <= '0;
                    if (spv_fall) begin
                        state <= VSTART;
                    end
                end

                VSTART: begin
                    if (ckv_rise) begin
                        if (!spv_s) begin
                            state <= WAIT_SPH;
                            pix_y <= '0;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                end

                WAIT_SPH: begin
                    if (spv_fall) begin
                        frame_err <= 1'b1;
                        state     <= VSTART;
                    end else if (ckv_rise && row_last) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (ckv_rise) begin
                            pix_y <= pix_y + 1'b1;
                        end
                        if (!sph_s) begin
                            state    <= DATA;
                            pix_x    <= '0;
                            byte_cnt <= 9'd0;
                        end
                    end
                end

                DATA: begin
                    if (cl_rise) begin
                        if (byte_cnt < H_CNT) begin
                            pix_valid <= 1'b1;
                            pix_data  <= d_s2;
                            pix_x     <= XW'(byte_cnt);
                        end
                        if (byte_cnt != 9'h1FF) begin
                            byte_cnt <= byte_cnt + 9'd1;
                        end
                    end
                    if (ckv_rise && row_last) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (ckv_rise) begin
                            pix_y <= pix_y + 1'b1;
                        end
                        if (sph_s) begin
                            state <= WAIT_LE;
                        end
                    end
                end

                WAIT_LE: begin
                    if (le_rise) begin
                        if (byte_cnt == H_CNT) begin
                            line_done <= 1'b1;
                        end else begin
                            line_err <= 1'b1;
                        end
                        if (row_last) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT_SPH;
                            if (ckv_rise) begin
                                pix_y <= pix_y + 1'b1;
                            end
                        end
                    end else if (ckv_rise) begin
                        if (row_last) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            pix_y <= pix_y + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
